// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard controller for the 5-stage RV32 pipeline. Combines M/W operand
// forwarding with load-use stalling (configurable bubble count), branch
// flushing, memory wait-state stalling and two saturating performance
// counters.
//
// Parameters
//   REG_ADDR_W        register index width
//   LOAD_USE_BUBBLES  stalled cycles per load-use hazard (1..7)
//   CNT_W             performance counter width
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   Rs1_D, Rs2_D              source registers of the instruction in Decode
//   Rs1_E, Rs2_E              source registers of the instruction in Execute
//   RD_E, RD_M, RD_W          destination registers in E/M/W
//   RegWriteM, RegWriteW      register write enables in M/W
//   LoadE                     instruction in E is a load
//   PCSrcE                    branch/jump taken in E
//   mem_req_M, mem_ready_M    data memory request / completion in M
//   cnt_clr                   synchronous clear of both counters
//   ForwardAE, ForwardBE      00 = regfile, 10 = ALU_ResultM, 01 = ResultW
//   StallF/D/E/M              hold the corresponding pipeline register
//   FlushD/E/W                bubble into the corresponding pipeline register
//   stall_cycles              cycles with StallF = 1 (saturating)
//   flush_events              cycles with a branch flush (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  mem_req_M,
  input  logic                  mem_ready_M,
  input  logic                  cnt_clr,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [2:0]       BUBBLE_INIT = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t          r_state;
  state_t          r_retState;
  state_t          w_nextState;
  state_t          w_retNext;
  state_t          w_effState;
  logic [2:0]      r_bubbleCnt;
  logic [2:0]      w_bubbleNext;
  logic            w_lu;
  logic            w_mw;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushEvents;

  // M-stage result is younger than W-stage result, so it wins; x0 is never
  // forwarded because it is hard-wired to zero.
  function automatic logic [1:0] fwdSel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  wrM,
    input logic [REG_ADDR_W-1:0] rdM,
    input logic                  wrW,
    input logic [REG_ADDR_W-1:0] rdW
  );
    if (wrM && (rdM != '0) && (rdM == rs))
      return 2'b10;
    else if (wrW && (rdW != '0) && (rdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_lu = LoadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  assign w_mw = mem_req_M && !mem_ready_M;

  // On the release cycle of a memory wait the saved state's rules apply
  // immediately, so the controller behaves as if it were already back there.
  assign w_effState = ((r_state == MEM_WAIT) && !w_mw) ? r_retState : r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_retState  <= RUN;
      r_bubbleCnt <= 3'd0;
    end else begin
      r_state     <= w_nextState;
      r_retState  <= w_retNext;
      r_bubbleCnt <= w_bubbleNext;
    end
  end

  // Next-state logic. A memory wait freezes the bubble counter and remembers
  // where to resume; the remembered state is captured only on entry.
  always_comb begin
    w_nextState  = w_effState;
    w_retNext    = r_retState;
    w_bubbleNext = r_bubbleCnt;
    if (w_mw) begin
      w_nextState = MEM_WAIT;
      if (r_state != MEM_WAIT)
        w_retNext = r_state;
    end else begin
      case (w_effState)
        RUN: begin
          if (!PCSrcE && w_lu && (LOAD_USE_BUBBLES > 1)) begin
            w_nextState  = LOAD_STALL;
            w_bubbleNext = BUBBLE_INIT;
          end
        end
        LOAD_STALL: begin
          if (r_bubbleCnt <= 3'd1) begin
            w_nextState  = RUN;
            w_bubbleNext = 3'd0;
          end else begin
            w_bubbleNext = r_bubbleCnt - 3'd1;
          end
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  // Output logic. Everything is gated by rst so the pipeline sees no
  // stall/flush/forward activity the instant reset is asserted.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (rst) begin
      ForwardAE = fwdSel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
      ForwardBE = fwdSel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
      if (w_mw) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        case (w_effState)
          RUN: begin
            if (PCSrcE) begin
              FlushD = 1'b1;
              FlushE = 1'b1;
            end else if (w_lu) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
            end
          end
          LOAD_STALL: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // FlushD is only ever raised by a taken branch, so it marks a flush event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stallCycles <= '0;
      r_flushEvents <= '0;
    end else if (cnt_clr) begin
      r_stallCycles <= '0;
      r_flushEvents <= '0;
    end else begin
      if (StallF && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + CNT_ONE;
      if (FlushD && (r_flushEvents != '1))
        r_flushEvents <= r_flushEvents + CNT_ONE;
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_events = r_flushEvents;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// Bench for hazard_ctrl_unit. Two instances share every input: dutA uses
// one load-use bubble and 32-bit counters, dutB uses three bubbles and 4-bit
// counters so saturation is reachable. The reference model tracks only
// "bubbles still owed" per instance and applies the priority rules directly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  localparam logic [6:0] LU = 7'b1100010;
  localparam logic [6:0] BR = 7'b0000110;
  localparam logic [6:0] MW = 7'b1111001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, mem_req_M, mem_ready_M, cnt_clr;

  logic [1:0]  fwdAA, fwdBA, fwdAB, fwdBB;
  logic        sFA, sDA, sEA, sMA, fDA, fEA, fWA;
  logic        sFB, sDB, sEB, sMB, fDB, fEB, fWB;
  logic [31:0] stallCntA, flushCntA;
  logic [3:0]  stallCntB, flushCntB;

  logic [6:0]  ctrl     [2];
  logic [1:0]  fwdA     [2];
  logic [1:0]  fwdB     [2];
  logic [31:0] stallAct [2];
  logic [31:0] flushAct [2];

  int checks = 0;
  int errors = 0;

  int     bub      [2];
  longint stallMdl [2];
  longint flushMdl [2];
  int     bubbles  [2] = '{1, 3};
  longint cntMax   [2] = '{64'hFFFF_FFFF, 64'd15};

  always #5 clk = ~clk;

  assign ctrl[0]     = {sFA, sDA, sEA, sMA, fDA, fEA, fWA};
  assign ctrl[1]     = {sFB, sDB, sEB, sMB, fDB, fEB, fWB};
  assign fwdA[0]     = fwdAA;
  assign fwdA[1]     = fwdAB;
  assign fwdB[0]     = fwdBA;
  assign fwdB[1]     = fwdBB;
  assign stallAct[0] = stallCntA;
  assign stallAct[1] = {28'd0, stallCntB};
  assign flushAct[0] = flushCntA;
  assign flushAct[1] = {28'd0, flushCntB};

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1), .CNT_W(32)) dutA (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .cnt_clr(cnt_clr), .ForwardAE(fwdAA), .ForwardBE(fwdBA),
    .StallF(sFA), .StallD(sDA), .StallE(sEA), .StallM(sMA),
    .FlushD(fDA), .FlushE(fEA), .FlushW(fWA),
    .stall_cycles(stallCntA), .flush_events(flushCntA)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(3), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .cnt_clr(cnt_clr), .ForwardAE(fwdAB), .ForwardBE(fwdBB),
    .StallF(sFB), .StallD(sDB), .StallE(sEB), .StallM(sMB),
    .FlushD(fDB), .FlushE(fEB), .FlushW(fWB),
    .stall_cycles(stallCntB), .flush_events(flushCntB)
  );

  // Reference model: the newest writer among M and W supplies the operand.
  function automatic logic [1:0] fwdExp(input logic [4:0] rs);
    if (!rst) return 2'b00;
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mwNow();
    return mem_req_M && !mem_ready_M;
  endfunction

  function automatic bit luNow();
    return LoadE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
  endfunction

  // Expected control bits {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  function automatic logic [6:0] ctrlExp(input int k);
    if (!rst) return 7'b0;
    if (mwNow()) return MW;
    if (bub[k] > 0) return LU;
    if (PCSrcE) return BR;
    if (luNow()) return LU;
    return 7'b0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      bub[k] = 0;
      stallMdl[k] = 0;
      flushMdl[k] = 0;
    end
  endtask

  task automatic modelClock();
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      e = ctrlExp(k);
      if (!rst) begin
        bub[k] = 0;
        stallMdl[k] = 0;
        flushMdl[k] = 0;
      end else begin
        if (!mwNow()) begin
          if (bub[k] > 0) bub[k]--;
          else if (!PCSrcE && luNow()) bub[k] = bubbles[k] - 1;
        end
        if (cnt_clr) begin
          stallMdl[k] = 0;
          flushMdl[k] = 0;
        end else begin
          if (e[6] && stallMdl[k] < cntMax[k]) stallMdl[k]++;
          if (e[2] && flushMdl[k] < cntMax[k]) flushMdl[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  task automatic clearInputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
    mem_req_M = 0; mem_ready_M = 0; cnt_clr = 0;
  endtask

  task automatic clearCounters();
    clearInputs();
    repeat (4) tick();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    modelReset();
    clearInputs();
    PCSrcE = 1; mem_req_M = 1; LoadE = 1; RD_E = 3; Rs1_D = 3;
    RegWriteM = 1; RD_M = 5; Rs1_E = 5; Rs2_E = 5;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (ctrl[k] !== 7'b0) begin errors++; $display("[TB] FAIL reset_ctrl dut%0d got %b expected 0", k, ctrl[k]); end
      if (fwdA[k] !== 2'b00 || fwdB[k] !== 2'b00) begin errors++; $display("[TB] FAIL reset_fwd dut%0d got %b/%b expected 00", k, fwdA[k], fwdB[k]); end
      if (stallAct[k] !== 0) begin errors++; $display("[TB] FAIL reset_stall_cnt dut%0d got %0d expected 0", k, stallAct[k]); end
      if (flushAct[k] !== 0) begin errors++; $display("[TB] FAIL reset_flush_cnt dut%0d got %0d expected 0", k, flushAct[k]); end
    end
    tick();
    clearInputs();
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctrl[k] !== 7'b0) begin errors++; $display("[TB] FAIL post_reset_idle dut%0d got %b expected 0", k, ctrl[k]); end
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] expA [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] expB [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
    clearInputs();
    for (int s = 0; s < 4; s++) begin
      RD_M = 5; RD_W = 5; Rs1_E = 5; Rs2_E = 5; RegWriteM = 1; RegWriteW = 1;
      if (s >= 1) RegWriteM = 0;
      if (s >= 2) Rs1_E = 0;
      if (s == 3) begin RD_W = 0; Rs2_E = 0; RegWriteM = 1; RD_M = 0; end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (fwdA[k] !== expA[s]) begin errors++; $display("[TB] FAIL fwd_a step%0d dut%0d got %b expected %b", s, k, fwdA[k], expA[s]); end
        if (fwdB[k] !== expB[s]) begin errors++; $display("[TB] FAIL fwd_b step%0d dut%0d got %b expected %b", s, k, fwdB[k], expB[s]); end
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_load_use();
    clearCounters();
    for (int c = 0; c < 4; c++) begin
      LoadE = (c == 0); RD_E = 3; Rs2_D = 3;
      @(negedge clk);
      checks += 2;
      if (ctrl[0] !== ((c == 0) ? LU : 7'b0)) begin errors++; $display("[TB] FAIL load_use_1 cyc%0d got %b expected %b", c, ctrl[0], (c == 0) ? LU : 7'b0); end
      if (ctrl[1] !== ((c < 3) ? LU : 7'b0)) begin errors++; $display("[TB] FAIL load_use_3 cyc%0d got %b expected %b", c, ctrl[1], (c < 3) ? LU : 7'b0); end
      tick();
    end
    checks += 2;
    if (stallAct[0] !== 1) begin errors++; $display("[TB] FAIL load_use_1_cnt got %0d expected 1", stallAct[0]); end
    if (stallAct[1] !== 3) begin errors++; $display("[TB] FAIL load_use_3_cnt got %0d expected 3", stallAct[1]); end
    clearInputs();
  endtask

  task automatic test_branch_load_use();
    clearCounters();
    PCSrcE = 1; LoadE = 1; RD_E = 3; Rs1_D = 3;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctrl[k] !== BR) begin errors++; $display("[TB] FAIL branch_over_lu dut%0d got %b expected %b", k, ctrl[k], BR); end
    end
    tick();
    clearInputs();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (ctrl[k] !== 7'b0) begin errors++; $display("[TB] FAIL branch_after dut%0d got %b expected 0", k, ctrl[k]); end
      if (flushAct[k] !== 1) begin errors++; $display("[TB] FAIL branch_flush_cnt dut%0d got %0d expected 1", k, flushAct[k]); end
      if (stallAct[k] !== 0) begin errors++; $display("[TB] FAIL branch_stall_cnt dut%0d got %0d expected 0", k, stallAct[k]); end
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clearCounters();
    for (int c = 0; c < 5; c++) begin
      clearInputs();
      if (c < 4) begin PCSrcE = 1; mem_req_M = 1; mem_ready_M = (c == 3); end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ctrl[k] !== ((c < 3) ? MW : (c == 3) ? BR : 7'b0)) begin
          errors++; $display("[TB] FAIL mem_wait cyc%0d dut%0d got %b expected %b", c, k, ctrl[k], (c < 3) ? MW : (c == 3) ? BR : 7'b0);
        end
      end
      tick();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (stallAct[k] !== 3) begin errors++; $display("[TB] FAIL mem_wait_stall_cnt dut%0d got %0d expected 3", k, stallAct[k]); end
      if (flushAct[k] !== 1) begin errors++; $display("[TB] FAIL mem_wait_flush_cnt dut%0d got %0d expected 1", k, flushAct[k]); end
    end
    tick();
  endtask

  task automatic test_mem_in_load_stall();
    logic [6:0] expA [6] = '{LU, MW, MW, 7'b0, 7'b0, 7'b0};
    logic [6:0] expB [6] = '{LU, MW, MW, LU, LU, 7'b0};
    clearCounters();
    for (int c = 0; c < 6; c++) begin
      clearInputs();
      if (c == 0) begin LoadE = 1; RD_E = 7; Rs1_D = 7; end
      if (c == 1 || c == 2) mem_req_M = 1;
      if (c == 3) begin mem_req_M = 1; mem_ready_M = 1; PCSrcE = 1; end
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (ctrl[0] !== BR) begin errors++; $display("[TB] FAIL mem_ls_release_branch dut0 got %b expected %b", ctrl[0], BR); end
      end else begin
        checks++;
        if (ctrl[0] !== expA[c]) begin errors++; $display("[TB] FAIL mem_ls cyc%0d dut0 got %b expected %b", c, ctrl[0], expA[c]); end
      end
      checks++;
      if (ctrl[1] !== expB[c]) begin errors++; $display("[TB] FAIL mem_ls cyc%0d dut1 got %b expected %b", c, ctrl[1], expB[c]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    clearCounters();
    LoadE = 1; RD_E = 3; Rs2_D = 3;
    @(negedge clk);
    tick();
    clearInputs();
    #2;
    checks++;
    if (ctrl[1] !== LU) begin errors++; $display("[TB] FAIL mid_stall_before_reset got %b expected %b", ctrl[1], LU); end
    rst = 0;
    modelReset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (ctrl[k] !== 7'b0) begin errors++; $display("[TB] FAIL async_reset_ctrl dut%0d got %b expected 0", k, ctrl[k]); end
      if (stallAct[k] !== 0) begin errors++; $display("[TB] FAIL async_reset_cnt dut%0d got %0d expected 0", k, stallAct[k]); end
    end
    @(negedge clk);
    rst = 1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ctrl[1] !== 7'b0) begin errors++; $display("[TB] FAIL no_carry_over cyc%0d got %b expected 0", c, ctrl[1]); end
      tick();
    end
  endtask

  task automatic test_saturation();
    clearCounters();
    LoadE = 1; RD_E = 9; Rs1_D = 9;
    repeat (20) tick();
    clearInputs();
    @(negedge clk);
    checks += 2;
    if (stallAct[0] !== 20) begin errors++; $display("[TB] FAIL sat_wide got %0d expected 20", stallAct[0]); end
    if (stallAct[1] !== 15) begin errors++; $display("[TB] FAIL sat_narrow got %0d expected 15", stallAct[1]); end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (stallAct[k] !== 0) begin errors++; $display("[TB] FAIL cnt_clr dut%0d got %0d expected 0", k, stallAct[k]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    logic [6:0] e;
    rst = 0;
    modelReset();
    clearInputs();
    tick();
    rst = 1;
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(99) != 0);
      if (!rst) modelReset();
      Rs1_D       = 5'($urandom_range(3));
      Rs2_D       = 5'($urandom_range(3));
      Rs1_E       = 5'($urandom_range(3));
      Rs2_E       = 5'($urandom_range(3));
      RD_E        = 5'($urandom_range(3));
      RD_M        = 5'($urandom_range(3));
      RD_W        = 5'($urandom_range(3));
      RegWriteM   = ($urandom_range(1) == 1);
      RegWriteW   = ($urandom_range(1) == 1);
      LoadE       = ($urandom_range(9) < 4);
      PCSrcE      = ($urandom_range(9) < 2);
      mem_req_M   = ($urandom_range(9) < 3);
      mem_ready_M = ($urandom_range(1) == 1);
      cnt_clr     = ($urandom_range(49) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = ctrlExp(k);
        checks += 5;
        if (fwdA[k] !== fwdExp(Rs1_E)) begin errors++; $display("[TB] FAIL rand_fwd_a n%0d dut%0d got %b expected %b", n, k, fwdA[k], fwdExp(Rs1_E)); end
        if (fwdB[k] !== fwdExp(Rs2_E)) begin errors++; $display("[TB] FAIL rand_fwd_b n%0d dut%0d got %b expected %b", n, k, fwdB[k], fwdExp(Rs2_E)); end
        if (ctrl[k] !== e) begin errors++; $display("[TB] FAIL rand_ctrl n%0d dut%0d got %b expected %b", n, k, ctrl[k], e); end
        if (stallAct[k] !== 32'(stallMdl[k])) begin errors++; $display("[TB] FAIL rand_stall_cnt n%0d dut%0d got %0d expected %0d", n, k, stallAct[k], stallMdl[k]); end
        if (flushAct[k] !== 32'(flushMdl[k])) begin errors++; $display("[TB] FAIL rand_flush_cnt n%0d dut%0d got %0d expected %0d", n, k, flushAct[k], flushMdl[k]); end
      end
      tick();
    end
    rst = 1;
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_mem_in_load_stall();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
